dtw_axis_sample_fifo: RTL and testbench
=======================================

Name: dtw_axis_sample_fifo

Overview:
- Parametrised successor to the DTW accelerator's AXI4-Stream sink FIFO.
- Accepts AXI4-Stream beats and unpacks each beat into SAMPLE_WIDTH samples, dropping lanes whose strobes are not all set.
- Stores each sample with a packet-last tag in a first-word-fall-through (FWFT) circular FIFO.
- Gives the DTW core sample, count, almost-full and whole-packet-available status.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, stream data width; a multiple of SAMPLE_WIDTH.
SAMPLE_WIDTH, 8, sample width; a multiple of 8. LANES = C_S_AXIS_TDATA_WIDTH/SAMPLE_WIDTH.
FIFO_DEPTH, 16, sample entries; a power of two, at least 4. CW = clog2(FIFO_DEPTH+1).
AFULL_THRESH, 12, dtw_fifo_afull asserts when count >= this value; must be 1..FIFO_DEPTH.

Ports:
S_AXIS_ACLK  in  1  clock
S_AXIS_ARESET  in  1  reset
S_AXIS_TVALID  in  1  beat valid
S_AXIS_TREADY  out  1  beat accepted when TVALID&&TREADY
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  beat data; lane 0 = LSBs
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers
S_AXIS_TLAST  in  1  packet boundary
dtw_fifo_rden  in  1  pop head entry
dtw_fifo_dout  out  SAMPLE_WIDTH  head sample (FWFT)
dtw_fifo_last  out  1  head sample is last of its packet
dtw_fifo_empty  out  1  FIFO empty
dtw_fifo_count  out  CW  entries held
dtw_fifo_afull  out  1  count >= AFULL_THRESH
dtw_pkt_count  out  CW  complete packets held (last-tagged entries)
dtw_pkt_avail  out  1  dtw_pkt_count != 0
err_clr  in  1  clears null_last_err
null_last_err  out  1  sticky: a TLAST beat had no valid lane

Interface:
- One clock; reset is synchronous and active-high.

Behaviour:
- Reset (S_AXIS_ARESET=1 at a clock edge): state=IDLE; read/write pointers, count and pkt_count = 0; beat register cleared.
- Reset outputs: TREADY=0 during reset; dtw_fifo_empty=1; dtw_fifo_afull=0; dtw_pkt_avail=0; null_last_err=0; dtw_fifo_last=0; dtw_fifo_dout=0.
- Reset mid-packet discards the beat being unpacked and all FIFO contents. No partial packet survives.
- Lane k is valid when all TSTRB bits of lane k are 1.
- FSM, IDLE:
  - TREADY=1.
  - On an accepted beat, latch TDATA, the per-lane valid mask and TLAST, then go to UNPACK.
  - If the mask is all-zero, do not enter UNPACK; if TLAST=1 on that beat, set null_last_err. The beat is discarded.
- FSM, UNPACK:
  - TREADY=0.
  - Each cycle, write the lowest remaining valid lane to the FIFO if not full, then clear that lane's mask bit. Invalid lanes are skipped at zero cost.
  - The written entry is tagged last=1 only if it is the highest valid lane of a TLAST beat.
  - When the final valid lane is written, return to IDLE. TREADY is 1 in the next cycle.
  - When the FIFO is full, the FSM stalls in UNPACK; nothing is lost.
- Throughput: one sample per cycle while unpacking, plus one cycle per beat for the IDLE accept. A 4-lane full beat takes 5 cycles.
- Latency: beat accepted at edge N → lane 0 written at edge N+1 → dtw_fifo_empty=0 and dout valid after edge N+1.
- Read path:
  - FWFT: dout/last are combinational from the head entry.
  - dtw_fifo_rden with empty=1 is ignored.
  - A pop advances the read pointer at the clock edge.
- Pointers: log2(FIFO_DEPTH) bits, wrapping naturally. Full is count==FIFO_DEPTH; a write at full is suppressed regardless of rden (no write-through).
- Simultaneous write and read: count unchanged. pkt_count changes by (written last) − (read last), so +1, −1 or 0.
- null_last_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
- Arithmetic: all counters are unsigned, width CW; they must never exceed FIFO_DEPTH or underflow.

Test Plan:
- Reset, then TDATA=0x44332211, TSTRB=0xF, TLAST=1 → reads return 0x11,0x22,0x33,0x44; last=1 only on 0x44. pkt_count goes 0→1 after the write of 0x44 and back to 0 on its pop.
- TSTRB=0x5, TDATA=0xDDCCBBAA, TLAST=1 → only 0xAA,0xCC stored; count=2; 0xCC tagged last; TREADY is high again 3 cycles after accept.
- TSTRB=0x0, TLAST=1 → nothing stored, null_last_err=1. err_clr=1 the next cycle → 0. Set and err_clr in the same cycle → stays 1.
- Push 5 full beats (20 samples, DEPTH=16) with no reads → TREADY stalls; count=16, afull=1. Popping 1 → 17th sample written; order preserved across pointer wrap.
- FIFO at count=8, with rden=1 each cycle during an unpack → count holds 8; no sample is lost or duplicated. rden on empty → count stays 0.
- Assert reset mid-UNPACK with count=6 → next cycle count=0, empty=1, pkt_count=0, state=IDLE. TREADY=1 after reset is released.

Source files
------------

// File: rtl/dtw_axis_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dtw_axis_sample_fifo
//  Purpose  : AXI4-Stream sink that unpacks each accepted beat into
//             SAMPLE_WIDTH samples and drops lanes with incomplete strobes.
//             Each kept sample is stored with a packet-last tag in a
//             first-word-fall-through circular FIFO.
//  Ports    : S_AXIS_*          - AXI4-Stream slave (clock, sync reset, beat)
//             dtw_fifo_rden     - pop the head entry (ignored when empty)
//             dtw_fifo_dout/last- head sample and its last tag (FWFT)
//             dtw_fifo_empty/count/afull - occupancy status
//             dtw_pkt_count/avail - complete packets held
//             err_clr / null_last_err - sticky "TLAST beat had no lane" flag
//  Revision : 1.0 - initial release
// ============================================================================
module dtw_axis_sample_fifo #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH         = 8,
    parameter int FIFO_DEPTH           = 16,
    parameter int AFULL_THRESH         = 12
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESET,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    input  logic                                dtw_fifo_rden,
    output logic [SAMPLE_WIDTH-1:0]             dtw_fifo_dout,
    output logic                                dtw_fifo_last,
    output logic                                dtw_fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     dtw_fifo_count,
    output logic                                dtw_fifo_afull,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     dtw_pkt_count,
    output logic                                dtw_pkt_avail,
    input  logic                                err_clr,
    output logic                                null_last_err
);

    localparam int LANES = C_S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int BPL   = SAMPLE_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UNPACK = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nx;

    logic [C_S_AXIS_TDATA_WIDTH-1:0] r_data;
    logic [LANES-1:0]           r_mask;
    logic                       r_last;

    logic [SAMPLE_WIDTH:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic [CW-1:0]              r_pkt_count;
    logic                       r_err;

    logic [LANES-1:0]           w_in_mask;
    logic                       w_accept;
    logic                       w_null_last;
    logic [LW-1:0]              w_lane;
    logic [LANES-1:0]           w_rem_mask;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_wr;
    logic                       w_wr_last;
    logic [SAMPLE_WIDTH-1:0]    w_wr_data;
    logic                       w_rd;
    logic [SAMPLE_WIDTH:0]      w_head;

    // A lane is kept only when every byte strobe inside it is set.
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane_mask
            assign w_in_mask[g] = &S_AXIS_TSTRB[g*BPL +: BPL];
        end
    endgenerate

    // Ready is gated by reset so no beat can be accepted while clearing.
    assign S_AXIS_TREADY = (r_state == S_IDLE) && !S_AXIS_ARESET;
    assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_null_last   = w_accept && (w_in_mask == '0) && S_AXIS_TLAST;

    // Lowest remaining valid lane; scanning downwards leaves the lowest hit.
    always_comb begin
        w_lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (r_mask[k]) begin
                w_lane = LW'(k);
            end
        end
    end

    assign w_rem_mask = r_mask & ~(LANES'(1) << w_lane);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_wr       = (r_state == S_UNPACK) && !w_full;
    // Only the highest valid lane of a TLAST beat carries the packet tag.
    assign w_wr_last  = r_last && (w_rem_mask == '0);
    assign w_wr_data  = r_data[w_lane*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign w_rd       = dtw_fifo_rden && !w_empty;
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_in_mask != '0)) begin
                    w_state_nx = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (w_wr && (w_rem_mask == '0)) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_mask  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_data <= S_AXIS_TDATA;
                r_mask <= w_in_mask;
                r_last <= S_AXIS_TLAST;
            end else if (w_wr) begin
                r_mask <= w_rem_mask;
            end
        end
    end

    // Storage array is not reset; pointers and count define its contents.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (w_wr && !S_AXIS_ARESET) begin
            r_mem[r_wr_ptr] <= {w_wr_last, w_wr_data};
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= r_count + CW'(w_wr) - CW'(w_rd);
            r_pkt_count <= r_pkt_count + CW'(w_wr && w_wr_last)
                                       - CW'(w_rd && w_head[SAMPLE_WIDTH]);
        end
    end

    // Setting the sticky error wins over a same-cycle clear.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_err <= 1'b0;
        end else if (w_null_last) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign dtw_fifo_dout  = w_empty ? '0   : w_head[SAMPLE_WIDTH-1:0];
    assign dtw_fifo_last  = w_empty ? 1'b0 : w_head[SAMPLE_WIDTH];
    assign dtw_fifo_empty = w_empty;
    assign dtw_fifo_count = r_count;
    assign dtw_fifo_afull = (r_count >= CW'(AFULL_THRESH));
    assign dtw_pkt_count  = r_pkt_count;
    assign dtw_pkt_avail  = (r_pkt_count != '0);
    assign null_last_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dtw_axis_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtw_axis_sample_fifo
//  Purpose  : Self-checking bench for dtw_axis_sample_fifo. A queue of
//             expected samples is filled on every accepted beat; a negedge
//             monitor pops it on every read and checks occupancy whenever
//             the sink is idle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dtw_axis_sample_fifo;

    localparam int W     = 32;
    localparam int SW    = 8;
    localparam int D     = 16;
    localparam int AF    = 12;
    localparam int LANES = W / SW;
    localparam int CW    = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            tvalid;
    logic            tready;
    logic [W-1:0]    tdata;
    logic [W/8-1:0]  tstrb;
    logic            tlast;
    logic            rden;
    logic [SW-1:0]   dout;
    logic            dlast;
    logic            empty;
    logic [CW-1:0]   count;
    logic            afull;
    logic [CW-1:0]   pkt_count;
    logic            pkt_avail;
    logic            err_clr;
    logic            err;

    always #5 clk = ~clk;

    dtw_axis_sample_fifo #(
        .C_S_AXIS_TDATA_WIDTH (W),
        .SAMPLE_WIDTH         (SW),
        .FIFO_DEPTH           (D),
        .AFULL_THRESH         (AF)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESET  (rst),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TREADY  (tready),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .dtw_fifo_rden  (rden),
        .dtw_fifo_dout  (dout),
        .dtw_fifo_last  (dlast),
        .dtw_fifo_empty (empty),
        .dtw_fifo_count (count),
        .dtw_fifo_afull (afull),
        .dtw_pkt_count  (pkt_count),
        .dtw_pkt_avail  (pkt_avail),
        .err_clr        (err_clr),
        .null_last_err  (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_%s at %0t", name, $time);
    endtask

    // ---------------- reference model + monitor ----------------
    typedef struct packed {
        logic [SW-1:0] d;
        logic          l;
    } ent_t;

    ent_t q[$];
    logic m_err = 1'b0;

    always @(negedge clk) begin
        int   lasts;
        int   hi;
        ent_t e;
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            chk("null_last_err", err, m_err);
            // Idle sink: every accepted beat has landed, so occupancy is exact.
            if (tready) begin
                lasts = 0;
                foreach (q[i]) lasts += int'(q[i].l);
                chk("count", count, q.size());
                chk("pkt_count", pkt_count, lasts);
                chk("pkt_avail", pkt_avail, lasts != 0);
                chk("empty", empty, q.size() == 0);
                chk("afull", afull, q.size() >= AF);
            end
            if (rden && !empty) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop: got 0x%0h with model empty", dout);
                end else begin
                    e = q.pop_front();
                    chk("dout", dout, e.d);
                    chk("last", dlast, e.l);
                end
            end
            if (tvalid && tready) begin
                hi = -1;
                for (int k = 0; k < LANES; k++) if (tstrb[k] == 1'b1) hi = k;
                for (int k = 0; k < LANES; k++) begin
                    if (tstrb[k] == 1'b1) begin
                        e.d = tdata[k*SW +: SW];
                        e.l = tlast && (k == hi);
                        q.push_back(e);
                    end
                end
                if (hi < 0 && tlast) m_err = 1'b1;
                else if (err_clr)    m_err = 1'b0;
            end else if (err_clr) begin
                m_err = 1'b0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [W/8-1:0] s, input logic l);
        int b;
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        b = 0;
        while (!tready && b < 200) begin
            tick();
            b++;
        end
        if (b >= 200) timeout("send_beat");
        tick();
        tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (!tready && b < 200) begin
            tick();
            b++;
        end
        if (b >= 200) timeout("wait_idle");
    endtask

    task automatic drain();
        int b;
        rden = 1'b1;
        b = 0;
        while (!(empty && tready) && b < 300) begin
            tick();
            b++;
        end
        if (b >= 300) timeout("drain");
        rden = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic acc;
        rst = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0;
        rden = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_tready", tready, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_afull", afull, 1'b0);
        chk("rst_pkt_avail", pkt_avail, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_last", dlast, 1'b0);
        chk("rst_dout", dout, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        tick();

        // Full beat with TLAST: four samples, only the top one tagged.
        send_beat(32'h44332211, 4'hF, 1'b1);
        wait_idle();
        chk("t1_count", count, 4);
        chk("t1_pkt", pkt_count, 1);
        rden = 1'b1;
        repeat (4) tick();
        rden = 1'b0;
        chk("t1_pkt_after", pkt_count, 0);
        chk("t1_empty", empty, 1'b1);

        // Sparse strobes: lanes 0 and 2 only, ready returns after two cycles.
        send_beat(32'hDDCCBBAA, 4'h5, 1'b1);
        n = 0;
        while (!tready && n < 20) begin tick(); n++; end
        chk("t2_gap", n, 2);
        chk("t2_count", count, 2);
        drain();
        send_beat(32'h87654321, 4'hF, 1'b0);
        n = 0;
        while (!tready && n < 20) begin tick(); n++; end
        chk("t2_full_gap", n, 4);
        send_beat(32'h0000_0099, 4'h1, 1'b1);
        drain();

        // Null TLAST beat and sticky error behaviour.
        send_beat(32'h12345678, 4'h0, 1'b1);
        chk("t3_err_set", err, 1'b1);
        chk("t3_count", count, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr", err, 1'b0);
        err_clr = 1'b1;
        send_beat(32'h0, 4'h0, 1'b1);
        chk("t3_set_wins", err, 1'b1);
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr2", err, 1'b0);

        // Overfill: five full beats, no reads.
        for (int b = 0; b < 5; b++) send_beat($urandom, 4'hF, b == 4);
        repeat (4) tick();
        chk("t4_count", count, 16);
        chk("t4_afull", afull, 1'b1);
        chk("t4_stall", tready, 1'b0);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        tick();
        chk("t4_refill", count, 16);
        drain();

        // Reads during unpack, then rden on empty.
        send_beat($urandom, 4'hF, 1'b0);
        send_beat($urandom, 4'hF, 1'b1);
        wait_idle();
        chk("t5_count8", count, 8);
        rden = 1'b1;
        send_beat($urandom, 4'hF, 1'b1);
        wait_idle();
        drain();
        rden = 1'b1;
        repeat (3) tick();
        rden = 1'b0;
        chk("t5_empty_rd", count, 0);

        // Reset while unpacking with six entries held.
        send_beat($urandom, 4'hF, 1'b1);
        send_beat($urandom, 4'h3, 1'b1);
        wait_idle();
        chk("t6_count6", count, 6);
        send_beat($urandom, 4'hF, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_pkt", pkt_count, 0);
        chk("t6_tready_rst", tready, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_tready", tready, 1'b1);
        tick();

        // Randomised traffic with varying read pressure.
        acc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!tvalid || acc) begin
                tvalid = ($urandom_range(0, 2) != 0);
                tdata  = $urandom;
                tstrb  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                tlast  = ($urandom_range(0, 2) == 0);
            end
            rden    = ($urandom_range(0, 3) < (i / 500));
            err_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            #1;
            acc = tvalid && tready;
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0; rst = 1'b0; err_clr = 1'b0;
        drain();
        chk("model_residue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
